aes_uart_ctrl: RTL and testbench

- Sequencing controller between the byte-wide UART RX/TX and the 128-bit fixed-latency AES encryption pipeline.
- Collects 16 plaintext bytes from UART RX and launches one AES block with a single-cycle start pulse.
- Waits the pipeline latency, captures the ciphertext, then streams 16 ciphertext bytes to UART TX under a valid/ready handshake.
- One block in flight at a time; inter-byte timeout and overrun errors are flagged.

---
 rtl/aes_uart_ctrl.sv | 145 ++++++++++++++
 tb/tb_aes_uart_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_uart_ctrl.sv
// Sequencer between a byte-wide UART and a fixed-latency 128-bit AES pipeline:
// gathers 16 RX bytes, launches one block, waits out the latency, streams ciphertext to TX.
//
// state  | meaning
// IDLE   | no block in progress, waiting for the first RX byte
// RECV   | collecting plaintext bytes, inter-byte timeout running
// LAUNCH | aes_start high for this single cycle
// WAIT   | counting down the AES pipeline latency
// SEND   | presenting ciphertext bytes to UART TX
module aes_uart_ctrl #(
  parameter int AES_LATENCY = 11,
  parameter int TIMEOUT     = 100000
) (
  input  logic         clk,
  input  logic         rs,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  input  logic         tx_ready,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  output logic [127:0] aes_pt,
  output logic         aes_start,
  input  logic [127:0] aes_ct,
  output logic         busy,
  output logic         err_timeout,
  output logic         err_overrun
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {S_IDLE, S_RECV, S_LAUNCH, S_WAIT, S_SEND} state_t;

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [7:0]     wait_q, wait_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [127:0]   rxbuf_q, rxbuf_d;
  logic [127:0]   pt_q, pt_d;
  logic [127:0]   ct_q, ct_d;
  logic           last_byte;
  logic           tmo_hit;

  assign last_byte = (cnt_q == 4'd15);
  // Expiry is the idle cycle that would bring the counter to TIMEOUT; a byte in that cycle wins.
  assign tmo_hit = (TIMEOUT > 0) && (state_q == S_RECV) && !rx_valid &&
                   (tmo_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rs) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wait_q  <= '0;
      tmo_q   <= '0;
      rxbuf_q <= '0;
      pt_q    <= '0;
      ct_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      tmo_q   <= tmo_d;
      rxbuf_q <= rxbuf_d;
      pt_q    <= pt_d;
      ct_q    <= ct_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    tmo_d   = tmo_q;
    rxbuf_d = rxbuf_q;
    pt_d    = pt_q;
    ct_d    = ct_q;
    unique case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          rxbuf_d = {120'b0, rx_data};
          cnt_d   = 4'd1;
          tmo_d   = '0;
          state_d = S_RECV;
        end
      end
      S_RECV: begin
        if (rx_valid) begin
          tmo_d = '0;
          if (last_byte) begin
            pt_d    = {rxbuf_q[119:0], rx_data};
            rxbuf_d = '0;
            cnt_d   = '0;
            state_d = S_LAUNCH;
          end else begin
            rxbuf_d = {rxbuf_q[119:0], rx_data};
            cnt_d   = cnt_q + 4'd1;
          end
        end else if (tmo_hit) begin
          rxbuf_d = '0;
          cnt_d   = '0;
          tmo_d   = '0;
          state_d = S_IDLE;
        end else if (TIMEOUT > 0) begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_LAUNCH: begin
        wait_d  = 8'(AES_LATENCY);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wait_q == 8'd1) begin
          ct_d    = aes_ct;
          wait_d  = '0;
          state_d = S_SEND;
        end else begin
          wait_d = wait_q - 8'd1;
        end
      end
      S_SEND: begin
        if (tx_ready) begin
          ct_d = {ct_q[119:0], 8'h00};
          if (last_byte) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q != S_IDLE);
    aes_start   = (state_q == S_LAUNCH);
    aes_pt      = pt_q;
    tx_valid    = (state_q == S_SEND);
    tx_data     = tx_valid ? ct_q[127:120] : 8'h00;
    err_timeout = tmo_hit;
    err_overrun = rx_valid &&
                  ((state_q == S_LAUNCH) || (state_q == S_WAIT) || (state_q == S_SEND));
  end

endmodule

// File: tb/tb_aes_uart_ctrl.sv
// Scoreboard bench for aes_uart_ctrl: directed blocks, backpressure, timeout,
// overrun, mid-operation reset and back-to-back traffic against a stand-in AES model.
module tb_aes_uart_ctrl;

  localparam int LAT = 11;
  localparam int TMO = 100;

  logic         clk = 1'b0;
  logic         rs;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic         tx_ready;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic [127:0] aes_pt;
  logic         aes_start;
  logic [127:0] aes_ct;
  logic         busy;
  logic         err_timeout;
  logic         err_overrun;

  aes_uart_ctrl #(.AES_LATENCY(LAT), .TIMEOUT(TMO)) dut (
    .clk(clk), .rs(rs), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_ready(tx_ready), .tx_data(tx_data), .tx_valid(tx_valid),
    .aes_pt(aes_pt), .aes_start(aes_start), .aes_ct(aes_ct), .busy(busy),
    .err_timeout(err_timeout), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ct_cyc = -1;
  logic [127:0] ct_val = '0;
  int rdy_mode = 0;
  int last_rx_cyc = 0;

  int           exp_start[$];
  logic [127:0] exp_pt[$];
  int           exp_txv[$];
  logic [7:0]   exp_tx[$];
  int           exp_tmo[$];
  int           exp_ovr[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Stand-in for the AES core: the one known vector, otherwise a cheap keyed shuffle.
  function automatic logic [127:0] aes_model(input logic [127:0] pt);
    if (pt == 128'h00112233445566778899aabbccddeeff)
      return 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    return {pt[63:0], pt[127:64]} ^ 128'h0123456789abcdeffedcba9876543210;
  endfunction

  // Cycle counter, AES output (valid only in its one cycle) and TX ready pattern.
  initial begin
    aes_ct   = '0;
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      aes_ct   = (cyc == ct_cyc) ? ct_val : {16{8'h3c}};
      tx_ready = (rdy_mode == 0) ? 1'b1 :
                 (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  logic         prev_v = 1'b0, prev_r = 1'b0, prev_rs = 1'b0;
  logic [7:0]   prev_d = '0;
  int           m_cyc;
  logic [127:0] m_pt;
  logic [7:0]   m_byte;

  always @(negedge clk) begin
    if (aes_start) begin
      if (exp_start.size() == 0) check("start_unexpected", 1, 0);
      else begin
        m_cyc = exp_start.pop_front();
        m_pt  = exp_pt.pop_front();
        check("start_cycle", cyc, m_cyc);
        check("aes_pt", aes_pt, m_pt);
      end
      ct_cyc = cyc + LAT;
      ct_val = aes_model(aes_pt);
    end
    if (prev_v && !prev_r && !prev_rs) begin
      check("tx_hold_valid", tx_valid, 1);
      check("tx_hold_data", tx_data, prev_d);
    end
    if (tx_valid && !prev_v) begin
      if (exp_txv.size() == 0) check("txv_unexpected", 1, 0);
      else begin
        m_cyc = exp_txv.pop_front();
        check("first_txv_cycle", cyc, m_cyc);
      end
    end
    if (tx_valid && tx_ready) begin
      if (exp_tx.size() == 0) check("tx_unexpected", 1, 0);
      else begin
        m_byte = exp_tx.pop_front();
        check("tx_byte", tx_data, m_byte);
      end
    end
    if (err_timeout) begin
      if (exp_tmo.size() == 0) check("timeout_unexpected", 1, 0);
      else begin
        m_cyc = exp_tmo.pop_front();
        check("timeout_cycle", cyc, m_cyc);
      end
    end
    if (err_overrun) begin
      if (exp_ovr.size() == 0) check("overrun_unexpected", 1, 0);
      else begin
        m_cyc = exp_ovr.pop_front();
        check("overrun_cycle", cyc, m_cyc);
      end
    end
    prev_v  = tx_valid;
    prev_r  = tx_ready;
    prev_d  = tx_data;
    prev_rs = rs;
  end

  // Called one time unit after a rising edge; the byte belongs to the current cycle.
  task automatic rx_byte(input logic [7:0] b, input int gap);
    rx_valid    = 1'b1;
    rx_data     = b;
    last_rx_cyc = cyc;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (gap - 1) begin @(posedge clk); #1; end
  endtask

  task automatic send_block(input logic [127:0] pt, input int gap, output int n);
    logic [127:0] ct;
    for (int i = 0; i < 15; i++) rx_byte(pt[127-8*i -: 8], gap);
    n  = cyc;
    ct = aes_model(pt);
    exp_start.push_back(n + 1);
    exp_pt.push_back(pt);
    exp_txv.push_back(n + 2 + LAT);
    for (int i = 0; i < 16; i++) exp_tx.push_back(ct[127-8*i -: 8]);
    rx_byte(pt[7:0], gap);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin @(posedge clk); #1; end
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    @(negedge clk);
    while ((busy || exp_tx.size() != 0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("done_busy", busy, 0);
    check("done_txq", exp_tx.size(), 0);
    @(posedge clk); #1;
  endtask

  localparam logic [127:0] PT_A = 128'h00112233445566778899aabbccddeeff;

  initial begin
    int n;
    rs       = 1'b1;
    rx_valid = 1'b0;
    rx_data  = '0;
    repeat (3) @(posedge clk);
    #1 rs = 1'b0;
    @(negedge clk);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_aes_pt", aes_pt, 0);
    check("rst_aes_start", aes_start, 0);
    check("rst_busy", busy, 0);
    check("rst_errs", {err_timeout, err_overrun}, 0);
    @(posedge clk); #1;

    // nominal block
    send_block(PT_A, 4, n);
    wait_done(200);

    // backpressure
    rdy_mode = 1;
    send_block(PT_A, 4, n);
    wait_done(400);
    rdy_mode = 0;

    // timeout after 5 bytes, then a fresh block
    for (int i = 0; i < 5; i++) rx_byte(8'h10 + 8'(i), 4);
    exp_tmo.push_back(last_rx_cyc + TMO);
    wait_until(last_rx_cyc + TMO + 5);
    @(negedge clk);
    check("tmo_idle", busy, 0);
    @(posedge clk); #1;
    send_block(128'hf0e1d2c3b4a5968778695a4b3c2d1e0f, 2, n);
    wait_done(200);

    // overrun in WAIT, in SEND and on the final TX accept
    send_block(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, 2, n);
    wait_until(n + 5);
    exp_ovr.push_back(cyc);
    rx_byte(8'haa, 1);
    wait_until(n + 16);
    exp_ovr.push_back(cyc);
    rx_byte(8'haa, 1);
    wait_until(n + 28);
    exp_ovr.push_back(cyc);
    rx_byte(8'haa, 1);
    wait_done(200);
    send_block(128'hdeadbeef0123456789abcdefcafef00d, 3, n);
    wait_done(200);

    // reset after 7 accepted TX bytes
    send_block(128'h55aa55aa11223344aabbccdd99887766, 1, n);
    wait_until(n + 19);
    @(negedge clk);
    rdy_mode = 2;
    @(posedge clk); #1;
    rs = 1'b1;
    @(posedge clk); #1;
    rs = 1'b0;
    rdy_mode = 0;
    @(negedge clk);
    check("mid_rst_tx_valid", tx_valid, 0);
    check("mid_rst_aes_start", aes_start, 0);
    check("mid_rst_aes_pt", aes_pt, 0);
    check("mid_rst_busy", busy, 0);
    exp_tx.delete();
    @(posedge clk); #1;
    send_block(128'h13579bdf2468ace0fedcba9876543210, 1, n);
    wait_done(200);

    // back-to-back: second block starts the cycle after the last TX accept
    send_block(128'h1111222233334444555566667777aaaa, 1, n);
    wait_until(n + 29);
    send_block(128'h9999888877776666555544443333bbbb, 1, n);
    wait_done(200);

    check("left_start", exp_start.size(), 0);
    check("left_txv", exp_txv.size(), 0);
    check("left_tmo", exp_tmo.size(), 0);
    check("left_ovr", exp_ovr.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
